// File: rtl/movseg_scanner.sv
// rtl/movseg_scanner.sv - moving seven-segment digit scanner with debounced step buttons, wrap/bounce ends, auto-scroll and tick divider; optional blink via MOVSEG_BLINK_EN
module movseg_scanner #(
  parameter int NUM_DIGITS     = 4,
  parameter int TICK_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int AUTO_TICKS     = 250,
  parameter int BLINK_TICKS    = 125,
  localparam int POS_W         = $clog2(NUM_DIGITS)
) (
  input  logic                  clk0,
  input  logic                  rst,
  input  logic                  btn_next,
  input  logic                  btn_prev,
  input  logic                  auto_en,
  input  logic                  bounce,
  input  logic [3:0]            nibble,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [POS_W-1:0]      pos,
  output logic                  tick
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam int DB_W  = $clog2(DEBOUNCE_TICKS + 1);
  localparam int AC_W  = $clog2(AUTO_TICKS + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_TICKS - 1);
  localparam logic [AC_W-1:0]  AUTO_LAST = AC_W'(AUTO_TICKS - 1);
  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(NUM_DIGITS - 1);
  localparam logic [POS_W-1:0] POS_ZERO  = '0;
  localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);

  // Reject parameter values the counters cannot represent.
  if (NUM_DIGITS < 2 || NUM_DIGITS > 16) begin : g_bad_num_digits
    $error("movseg_scanner: NUM_DIGITS out of range 2..16");
  end
  if (TICK_DIV < 2) begin : g_bad_tick_div
    $error("movseg_scanner: TICK_DIV must be >= 2");
  end
  if (DEBOUNCE_TICKS < 1) begin : g_bad_debounce
    $error("movseg_scanner: DEBOUNCE_TICKS must be >= 1");
  end
  if (AUTO_TICKS < 1) begin : g_bad_auto
    $error("movseg_scanner: AUTO_TICKS must be >= 1");
  end
  if (BLINK_TICKS < 1) begin : g_bad_blink
    $error("movseg_scanner: BLINK_TICKS must be >= 1");
  end

  typedef enum logic [1:0] {
    MANUAL    = 2'd0,
    AUTO_UP   = 2'd1,
    AUTO_DOWN = 2'd2
  } state_t;

  state_t                     state;
  logic [DIV_W-1:0]           div;
  logic [1:0]                 btn_raw;
  logic [1:0]                 btn_lvl;
  logic [1:0][DB_W-1:0]       btn_cnt;
  logic [1:0]                 rise;
  logic                       step_n;
  logic                       step_p;
  logic [AC_W-1:0]            acnt;
  logic [POS_W-1:0]           pos_up;
  logic [POS_W-1:0]           pos_dn;
  logic                       an_blank;

  // Active-low hex glyphs, bit order {a,b,c,d,e,f,g}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b0000001;
      4'h1: hex7 = 7'b1001111;
      4'h2: hex7 = 7'b0010010;
      4'h3: hex7 = 7'b0000110;
      4'h4: hex7 = 7'b1001100;
      4'h5: hex7 = 7'b0100100;
      4'h6: hex7 = 7'b0100000;
      4'h7: hex7 = 7'b0001111;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0000100;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b1100000;
      4'hC: hex7 = 7'b0110001;
      4'hD: hex7 = 7'b1000010;
      4'hE: hex7 = 7'b0110000;
      default: hex7 = 7'b0111000;
    endcase
  endfunction

  // Tick divider: free-running 0..TICK_DIV-1.
  always_ff @(posedge clk0) begin
    if (!rst) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + DIV_W'(1);
    end
  end

  assign tick    = (div == DIV_LAST);
  assign btn_raw = {btn_prev, btn_next};

  // Press pulse fires in the cycle whose tick completes a 0->1 debounce flip.
  always_comb begin
    rise = '0;
    for (int i = 0; i < 2; i++) begin
      rise[i] = tick && (btn_raw[i] != btn_lvl[i]) && (btn_cnt[i] == DB_LAST) && !btn_lvl[i];
    end
  end

  assign step_n = rise[0];
  assign step_p = rise[1];

  // Per-button debounce, sampled only on tick.
  always_ff @(posedge clk0) begin
    if (!rst) begin
      btn_lvl <= '0;
      btn_cnt <= '0;
    end else if (tick) begin
      for (int i = 0; i < 2; i++) begin
        if (btn_raw[i] != btn_lvl[i]) begin
          if (btn_cnt[i] == DB_LAST) begin
            btn_lvl[i] <= ~btn_lvl[i];
            btn_cnt[i] <= '0;
          end else begin
            btn_cnt[i] <= btn_cnt[i] + DB_W'(1);
          end
        end else begin
          btn_cnt[i] <= '0;
        end
      end
    end
  end

  // Wrapping neighbours of the current position.
  always_comb begin
    pos_up = (pos == POS_LAST) ? POS_ZERO : pos + POS_ONE;
    pos_dn = (pos == POS_ZERO) ? POS_LAST : pos - POS_ONE;
  end

  // Position FSM; direction is implied by the state (DOWN only in AUTO_DOWN).
  always_ff @(posedge clk0) begin
    if (!rst) begin
      state <= MANUAL;
      pos   <= '0;
      acnt  <= '0;
    end else begin
      case (state)
        MANUAL: begin
          if (auto_en) begin
            state <= AUTO_UP;
            acnt  <= '0;
          end else if (step_n && !step_p) begin
            if (!(bounce && pos == POS_LAST)) pos <= pos_up;
          end else if (step_p && !step_n) begin
            if (!(bounce && pos == POS_ZERO)) pos <= pos_dn;
          end
        end
        AUTO_UP, AUTO_DOWN: begin
          if (!auto_en) begin
            state <= MANUAL;
            acnt  <= '0;
          end else if (step_n != step_p) begin
            state <= step_n ? AUTO_UP : AUTO_DOWN;
            acnt  <= '0;
          end else if (tick) begin
            if (acnt == AUTO_LAST) begin
              acnt <= '0;
              if (!bounce) begin
                pos <= (state == AUTO_UP) ? pos_up : pos_dn;
              end else if (state == AUTO_UP) begin
                // Already parked at the top (bounce enabled late): turn around now.
                if (pos == POS_LAST) begin
                  pos   <= pos_dn;
                  state <= AUTO_DOWN;
                end else begin
                  pos <= pos_up;
                  if (pos_up == POS_LAST) state <= AUTO_DOWN;
                end
              end else begin
                if (pos == POS_ZERO) begin
                  pos   <= pos_up;
                  state <= AUTO_UP;
                end else begin
                  pos <= pos_dn;
                  if (pos_dn == POS_ZERO) state <= AUTO_UP;
                end
              end
            end else begin
              acnt <= acnt + AC_W'(1);
            end
          end
        end
        default: begin
          state <= MANUAL;
          acnt  <= '0;
        end
      endcase
    end
  end

`ifdef MOVSEG_BLINK_EN
  localparam int BL_W = $clog2(BLINK_TICKS + 1);
  localparam logic [BL_W-1:0] BLINK_LAST = BL_W'(BLINK_TICKS - 1);

  logic [BL_W-1:0]  bcnt;
  logic             phase;
  logic [POS_W-1:0] pos_q;
  logic             moved;

  assign moved = (pos != pos_q);

  // Blink phase; any move restarts the lit half so the new digit shows at once.
  always_ff @(posedge clk0) begin
    if (!rst) begin
      bcnt  <= '0;
      phase <= 1'b0;
      pos_q <= '0;
    end else begin
      pos_q <= pos;
      if (moved) begin
        bcnt  <= '0;
        phase <= 1'b0;
      end else if (tick) begin
        if (bcnt == BLINK_LAST) begin
          bcnt  <= '0;
          phase <= ~phase;
        end else begin
          bcnt <= bcnt + BL_W'(1);
        end
      end
    end
  end

  assign an_blank = phase && !moved;
`else
  assign an_blank = 1'b0;
`endif

  // Registered display drive, one cycle behind pos.
  always_ff @(posedge clk0) begin
    if (!rst) begin
      an  <= '1;
      seg <= 7'h7F;
    end else begin
      an  <= an_blank ? '1 : ~(NUM_DIGITS'(1) << pos);
      seg <= hex7(nibble);
    end
  end

endmodule

// File: tb/tb_movseg_scanner.sv
// tb/tb_movseg_scanner.sv - directed self-checking bench for movseg_scanner
module tb_movseg_scanner;

  logic       clk0;
  logic       rst;
  logic       btn_next;
  logic       btn_prev;
  logic       auto_en;
  logic       bounce;
  logic [3:0] nibble;
  logic [6:0] seg;
  logic [3:0] an;
  logic [1:0] pos;
  logic       tick;

  int n_cmp;
  int n_bad;

  movseg_scanner #(
    .NUM_DIGITS(4), .TICK_DIV(4), .DEBOUNCE_TICKS(2), .AUTO_TICKS(3), .BLINK_TICKS(2)
  ) dut (
    .clk0(clk0), .rst(rst), .btn_next(btn_next), .btn_prev(btn_prev),
    .auto_en(auto_en), .bounce(bounce), .nibble(nibble),
    .seg(seg), .an(an), .pos(pos), .tick(tick)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // With blinking compiled in, a stationary digit may legitimately be blanked.
  task automatic chk_an(input string tag, input logic [3:0] exp);
`ifdef MOVSEG_BLINK_EN
    if (an === 4'b1111) chk(tag, an, 4'b1111);
    else chk(tag, an, exp);
`else
    chk(tag, an, exp);
`endif
  endtask

  // Returns at the falling edge inside the k-th tick cycle from now.
  task automatic wait_ticks(input int k);
    for (int i = 0; i < k; i++) begin
      int c;
      c = 0;
      do begin
        @(negedge clk0);
        c++;
      end while (!tick && c < 20);
      n_cmp++;
      assert (tick === 1'b1) else begin
        n_bad++;
        $error("FAIL tick_timeout: observed %b expected 1", tick);
      end
    end
  endtask

  task automatic hold_btns(input logic n, input logic p, input int ticks);
    btn_next = n;
    btn_prev = p;
    wait_ticks(ticks);
    @(negedge clk0);
  endtask

  task automatic press_next();
    hold_btns(1'b1, 1'b0, 3);
    hold_btns(1'b0, 1'b0, 3);
  endtask

  task automatic press_prev();
    hold_btns(1'b0, 1'b1, 3);
    hold_btns(1'b0, 1'b0, 3);
  endtask

  initial begin
    logic [1:0] auto_exp [7];
    logic [3:0] prev_an;
    int on_cnt;
    int off_cnt;
    int c;

    n_cmp    = 0;
    n_bad    = 0;
    rst      = 1'b0;
    btn_next = 1'b0;
    btn_prev = 1'b0;
    auto_en  = 1'b0;
    bounce   = 1'b0;
    nibble   = 4'h0;

    // Reset state
    repeat (3) @(posedge clk0);
    @(negedge clk0);
    chk("rst_an", an, 4'b1111);
    chk("rst_seg", seg, 7'h7F);
    chk("rst_pos", pos, 2'd0);
    chk("rst_tick", tick, 1'b0);
    rst = 1'b1;
    @(negedge clk0);
    chk("post_rst_an", an, 4'b1110);
    chk("post_rst_seg0", seg, 7'b0000001);
    chk("tick_c1", tick, 1'b0);
    @(negedge clk0);
    chk("tick_c2", tick, 1'b0);
    @(negedge clk0);
    chk("tick_c3", tick, 1'b1);
    @(negedge clk0);
    chk("tick_c4", tick, 1'b0);
    wait_ticks(1);
    @(negedge clk0);

    // Manual wrap with glyph checks
    nibble = 4'h8;
    press_next();
    chk("wrap_pos1", pos, 2'd1);
    chk_an("wrap_an1", 4'b1101);
    chk("seg_8", seg, 7'b0000000);
    nibble = 4'hA;
    press_next();
    chk("wrap_pos2", pos, 2'd2);
    chk_an("wrap_an2", 4'b1011);
    chk("seg_A", seg, 7'b0001000);
    nibble = 4'hF;
    press_next();
    chk("wrap_pos3", pos, 2'd3);
    chk_an("wrap_an3", 4'b0111);
    chk("seg_F", seg, 7'b0111000);
    nibble = 4'h3;
    press_next();
    chk("wrap_pos0", pos, 2'd0);
    chk_an("wrap_an0", 4'b1110);
    chk("seg_3", seg, 7'b0000110);
    press_prev();
    chk("wrap_prev_pos3", pos, 2'd3);

    // Debounce: one-tick glitch, then a long hold steps once
    hold_btns(1'b1, 1'b0, 1);
    hold_btns(1'b0, 1'b0, 3);
    chk("glitch_pos", pos, 2'd3);
    hold_btns(1'b1, 1'b0, 2);
    chk("deb_2tick_pos", pos, 2'd0);
    hold_btns(1'b1, 1'b0, 4);
    chk("deb_held_pos", pos, 2'd0);
    hold_btns(1'b0, 1'b0, 3);
    chk("deb_release_pos", pos, 2'd0);

    // Clamp and simultaneous presses
    bounce = 1'b1;
    press_prev();
    chk("clamp_low_pos", pos, 2'd0);
    bounce = 1'b0;
    press_prev();
    chk("to_top_pos", pos, 2'd3);
    bounce = 1'b1;
    press_next();
    chk("clamp_high_pos", pos, 2'd3);
    hold_btns(1'b1, 1'b1, 3);
    hold_btns(1'b0, 1'b0, 3);
    chk("both_clamp_pos", pos, 2'd3);
    bounce = 1'b0;
    hold_btns(1'b1, 1'b1, 3);
    hold_btns(1'b0, 1'b0, 3);
    chk("both_wrap_pos", pos, 2'd3);
    press_next();
    chk("auto_start_pos", pos, 2'd0);

    // Auto bounce from pos 0, one step per 3 ticks (12 cycles)
    bounce  = 1'b1;
    auto_en = 1'b1;
    auto_exp = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};
    wait_ticks(2);
    @(negedge clk0);
    chk("auto_not_yet", pos, 2'd0);
    wait_ticks(1);
    @(negedge clk0);
    chk("auto_step0", pos, auto_exp[0]);
    for (int i = 1; i < 7; i++) begin
      wait_ticks(3);
      @(negedge clk0);
      chk($sformatf("auto_step%0d", i), pos, auto_exp[i]);
    end

    // btn_prev while moving up: turn down, restart counter, no move on that edge
    hold_btns(1'b0, 1'b1, 2);
    chk("force_dn_pos", pos, 2'd1);
    btn_prev = 1'b0;
    wait_ticks(1);
    @(negedge clk0);
    chk("force_dn_restart", pos, 2'd1);
    wait_ticks(2);
    @(negedge clk0);
    chk("force_dn_step", pos, 2'd0);

    // Leaving auto holds the position
    auto_en = 1'b0;
    wait_ticks(4);
    @(negedge clk0);
    chk("manual_hold_pos", pos, 2'd0);

`ifdef MOVSEG_BLINK_EN
    // Blink: 8 cycles lit, 8 cycles blank
    prev_an = an;
    c = 0;
    do begin
      prev_an = an;
      @(negedge clk0);
      c++;
    end while (!(prev_an == 4'b1111 && an != 4'b1111) && c < 40);
    chk("blink_found", an, 4'b1110);
    on_cnt = 1;
    off_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk0);
      if (an == 4'b1110) on_cnt++;
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk0);
      if (an == 4'b1111) off_cnt++;
    end
    chk("blink_on_len", on_cnt, 8);
    chk("blink_off_len", off_cnt, 8);
    @(negedge clk0);
    chk("blink_relit", an, 4'b1110);

    // Step landing mid-blank lights the new digit next cycle
    wait_ticks(1);
    @(negedge clk0);
    btn_next = 1'b1;
    wait_ticks(1);
    @(negedge clk0);
    @(negedge clk0);
    chk("blink_off_before_step", an, 4'b1111);
    wait_ticks(1);
    @(negedge clk0);
    chk("blink_step_pos", pos, 2'd1);
    @(negedge clk0);
    chk("blink_step_lit", an, 4'b1101);
    hold_btns(1'b0, 1'b0, 3);
`endif

    // Reset mid-debounce leaves no residual step
    hold_btns(1'b1, 1'b0, 3);
    hold_btns(1'b0, 1'b0, 3);
    btn_next = 1'b1;
    wait_ticks(1);
    @(negedge clk0);
    rst = 1'b0;
    @(negedge clk0);
    @(negedge clk0);
    chk("midrst_an", an, 4'b1111);
    chk("midrst_pos", pos, 2'd0);
    rst = 1'b1;
    wait_ticks(1);
    @(negedge clk0);
    chk("midrst_no_step", pos, 2'd0);
    btn_next = 1'b0;
    @(negedge clk0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
